// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and defaults for the PC sequencer. It holds the
//               fetch/issue state encoding and the default reset PC and
//               instruction size.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h8000_0000;
  localparam int unsigned INST_BYTES_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_sel
// Description : Combinational next-PC selection. Priority is trap target,
//               then redirect target, then pc + INST_BYTES (the addition is
//               modulo 2^32). Flags a target with a nonzero low 2 bits.
// Ports       : i_pc              current architectural PC
//               i_trap_valid      trap entry requested
//               i_trap_target     trap entry address
//               i_redirect_valid  branch/jump taken
//               i_redirect_target branch/jump address
//               o_dnpc            selected next PC
//               o_misaligned      o_dnpc[1:0] is nonzero
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int unsigned INST_BYTES = INST_BYTES_DEFAULT
) (
  input  logic [31:0] i_pc,
  input  logic        i_trap_valid,
  input  logic [31:0] i_trap_target,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic [31:0] o_dnpc,
  output logic        o_misaligned
);

  localparam logic [31:0] C_INC = 32'(INST_BYTES);

  logic [31:0] w_seq_pc;

  // Carry out of bit 31 is dropped, so the top of the address space wraps to 0.
  assign w_seq_pc = i_pc + C_INC;

  always_comb begin
    o_dnpc = w_seq_pc;
    if (i_trap_valid) begin
      o_dnpc = i_trap_target;
    end else if (i_redirect_valid) begin
      o_dnpc = i_redirect_target;
    end
  end

  assign o_misaligned = |o_dnpc[1:0];

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch/issue sequencer. It requests an instruction at pc,
//               waits for the response, offers the instruction to execute,
//               and on commit advances pc to the selected next PC. A fetch
//               error, a misaligned next PC or a halt request parks the
//               block in S_HALT until reset.
// Ports       : clk, rst                     clock, async active-high reset
//               imem_req_valid/ready/addr    fetch request channel
//               imem_rsp_valid/inst/err      fetch response channel
//               inst_valid/inst/exec_ready   issue handshake to execute
//               redirect_*, trap_*, halt_req control-flow inputs at commit
//               pc, dnpc                     current and next PC
//               halted, fault, retire_cnt    status
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned INST_BYTES = INST_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_inst,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        exec_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_target,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] dnpc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retire_cnt
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_retire;
  logic        r_fault;
  logic        w_fault_nxt;
  logic        w_latch_inst;
  logic        w_pc_update;
  logic [31:0] w_dnpc;
  logic        w_misaligned;

  pc_next_sel #(
    .INST_BYTES (INST_BYTES)
  ) u_next_sel (
    .i_pc              (r_pc),
    .i_trap_valid      (trap_valid),
    .i_trap_target     (trap_target),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .o_dnpc            (w_dnpc),
    .o_misaligned      (w_misaligned)
  );

  // Next-state and handshake outputs. The response channel is only looked
  // at in S_WAIT and the control-flow inputs only in a commit cycle, so
  // stray activity elsewhere falls through to the defaults.
  always_comb begin
    w_state_nxt    = r_state;
    w_fault_nxt    = 1'b0;
    w_latch_inst   = 1'b0;
    w_pc_update    = 1'b0;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (r_state)
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = S_HALT;
          end else begin
            w_latch_inst = 1'b1;
            w_state_nxt  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        inst_valid = 1'b1;
        if (exec_ready) begin
          if (w_misaligned) begin
            // The faulting commit does not retire and leaves pc unchanged.
            w_fault_nxt = 1'b1;
            w_state_nxt = S_HALT;
          end else begin
            w_pc_update = 1'b1;
            w_state_nxt = halt_req ? S_HALT : S_REQ;
          end
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_REQ;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_inst   <= 32'd0;
      r_retire <= 32'd0;
    end else begin
      if (w_latch_inst) begin
        r_inst <= imem_rsp_inst;
      end
      if (w_pc_update) begin
        r_pc     <= w_dnpc;
        r_retire <= r_retire + 32'd1;
      end
    end
  end

  assign imem_req_addr = r_pc;
  assign pc            = r_pc;
  assign dnpc          = w_dnpc;
  assign inst          = r_inst;
  assign retire_cnt    = r_retire;
  assign fault         = r_fault;
  assign halted        = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. A transaction-level
//               model tracks the expected pc and retire count from the
//               next-PC rules; a second instance with RESET_PC=FFFF_FFFC
//               covers address wrap and reset during an outstanding fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_w;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_inst;
  logic        imem_rsp_err;
  logic        exec_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        halt_req;

  logic        imem_req_valid, inst_valid, halted, fault;
  logic [31:0] imem_req_addr, inst, pc, dnpc, retire_cnt;

  logic        w_req_valid, w_inst_valid, w_halted, w_fault;
  logic [31:0] w_req_addr, w_inst, w_pc, w_dnpc, w_retire;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;

  always #5 clk = ~clk;

  pc_sequencer u_dut (
    .clk (clk), .rst (rst),
    .imem_req_valid (imem_req_valid), .imem_req_ready (imem_req_ready),
    .imem_req_addr (imem_req_addr), .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_inst (imem_rsp_inst), .imem_rsp_err (imem_rsp_err),
    .inst_valid (inst_valid), .inst (inst), .exec_ready (exec_ready),
    .redirect_valid (redirect_valid), .redirect_target (redirect_target),
    .trap_valid (trap_valid), .trap_target (trap_target),
    .halt_req (halt_req), .pc (pc), .dnpc (dnpc), .halted (halted),
    .fault (fault), .retire_cnt (retire_cnt)
  );

  pc_sequencer #(.RESET_PC (WRAP_PC)) u_wrap (
    .clk (clk), .rst (rst_w),
    .imem_req_valid (w_req_valid), .imem_req_ready (imem_req_ready),
    .imem_req_addr (w_req_addr), .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_inst (imem_rsp_inst), .imem_rsp_err (imem_rsp_err),
    .inst_valid (w_inst_valid), .inst (w_inst), .exec_ready (exec_ready),
    .redirect_valid (redirect_valid), .redirect_target (redirect_target),
    .trap_valid (trap_valid), .trap_target (trap_target),
    .halt_req (halt_req), .pc (w_pc), .dnpc (w_dnpc), .halted (w_halted),
    .fault (w_fault), .retire_cnt (w_retire)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_inst   = 32'd0;
    imem_rsp_err    = 1'b0;
    exec_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    trap_valid      = 1'b0;
    trap_target     = 32'd0;
    halt_req        = 1'b0;
  endtask

  // Random activity on inputs that must be ignored in the current phase.
  task automatic stray(input logic with_rsp);
    redirect_valid  = 1'($urandom_range(0, 1));
    redirect_target = $urandom;
    trap_valid      = 1'($urandom_range(0, 1));
    trap_target     = $urandom;
    halt_req        = 1'($urandom_range(0, 1));
    if (with_rsp) begin
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_inst  = $urandom;
      imem_rsp_err   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pc  = RST_PC;
    m_ret = 32'd0;
  endtask

  // Drives one instruction through request, response and commit with the
  // given stall lengths; returns what was observed for the caller to judge.
  task automatic drive_instr(
    input  int          rdy_dly, input int rsp_dly, input int ex_dly,
    input  logic        err, input logic rv, input logic [31:0] rt,
    input  logic        tv, input logic [31:0] tt, input logic hr,
    input  logic [31:0] iw,
    output logic [31:0] req_addr, output logic [31:0] got_inst,
    output logic [31:0] dnpc_obs, output logic stable, output logic timeout);
    int          n;
    logic [31:0] pc0;
    req_addr = '0; got_inst = '0; dnpc_obs = '0; stable = 1'b1; timeout = 1'b0;
    clear_inputs();
    n = 0;
    while (!imem_req_valid && n < 20) begin tick(); n++; end
    if (!imem_req_valid) begin timeout = 1'b1; return; end
    req_addr = imem_req_addr;
    pc0      = pc;
    for (int i = 0; i < rdy_dly; i++) begin
      stray(1'b1);
      tick();
      if (!imem_req_valid || imem_req_addr !== req_addr || pc !== pc0) stable = 1'b0;
    end
    clear_inputs();
    imem_req_ready = 1'b1;
    tick();
    clear_inputs();
    for (int i = 0; i < rsp_dly; i++) begin
      stray(1'b0);
      tick();
      if (pc !== pc0) stable = 1'b0;
    end
    clear_inputs();
    imem_rsp_valid = 1'b1;
    imem_rsp_inst  = iw;
    imem_rsp_err   = err;
    tick();
    clear_inputs();
    if (err) return;
    n = 0;
    while (!inst_valid && n < 20) begin tick(); n++; end
    if (!inst_valid) begin timeout = 1'b1; return; end
    got_inst = inst;
    for (int i = 0; i < ex_dly; i++) begin
      stray(1'b1);
      tick();
      if (!inst_valid || inst !== got_inst || pc !== pc0) stable = 1'b0;
    end
    clear_inputs();
    redirect_valid  = rv;
    redirect_target = rt;
    trap_valid      = tv;
    trap_target     = tt;
    halt_req        = hr;
    exec_ready      = 1'b1;
    #1;
    dnpc_obs = dnpc;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (pc !== RST_PC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    n_cmp++; if (retire_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_retire: got %h want 0", retire_cnt); end
    n_cmp++; if (inst !== 32'd0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst); end
    n_cmp++; if (fault !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL reset_flags: fault=%b halted=%b want 0/0", fault, halted); end
    rst = 1'b0;
    tick();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_bad++; $display("FAIL reset_req: valid=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC);
    end
    m_pc  = RST_PC;
    m_ret = 32'd0;
  endtask

  // Everything arrives immediately: exactly REQ, WAIT, ISSUE per instruction.
  task automatic test_sequential();
    logic [31:0] iw;
    clear_inputs();
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    exec_ready     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iw = m_pc ^ 32'h1357_9BDF;
      imem_rsp_inst = iw;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== m_pc) begin
        n_bad++; $display("FAIL seq_req%0d: valid=%b addr=%h want 1/%h", i, imem_req_valid, imem_req_addr, m_pc);
      end
      tick();
      n_cmp++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_bad++; $display("FAIL seq_wait%0d: req=%b iv=%b want 0/0", i, imem_req_valid, inst_valid);
      end
      tick();
      n_cmp++; if (inst_valid !== 1'b1 || inst !== iw) begin
        n_bad++; $display("FAIL seq_issue%0d: iv=%b inst=%h want 1/%h", i, inst_valid, inst, iw);
      end
      tick();
      m_pc  = m_pc + 32'd4;
      m_ret = m_ret + 32'd1;
    end
    clear_inputs();
    n_cmp++; if (retire_cnt !== 32'd3 || pc !== 32'h8000_000C) begin
      n_bad++; $display("FAIL seq_end: retire=%0d pc=%h want 3/8000000c", retire_cnt, pc);
    end
  endtask

  task automatic test_branch_trap();
    logic [31:0] a, g, d;
    logic        st, to;
    drive_instr(0, 0, 0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'd0, 1'b0, 32'hAAAA_0001, a, g, d, st, to);
    n_cmp++; if (to || a !== m_pc || g !== 32'hAAAA_0001) begin
      n_bad++; $display("FAIL br_fetch: to=%b addr=%h inst=%h want %h/aaaa0001", to, a, g, m_pc);
    end
    n_cmp++; if (d !== 32'h8000_0100 || pc !== 32'h8000_0100) begin
      n_bad++; $display("FAIL br_pc: dnpc=%h pc=%h want 80000100", d, pc);
    end
    m_pc = 32'h8000_0100; m_ret = m_ret + 32'd1;
    drive_instr(0, 0, 0, 1'b0, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_1000, 1'b0, 32'hAAAA_0002, a, g, d, st, to);
    n_cmp++; if (to || a !== 32'h8000_0100) begin
      n_bad++; $display("FAIL trap_fetch: to=%b addr=%h want 80000100", to, a);
    end
    n_cmp++; if (d !== 32'h8000_1000 || pc !== 32'h8000_1000) begin
      n_bad++; $display("FAIL trap_pc: dnpc=%h pc=%h want 80001000", d, pc);
    end
    m_pc = 32'h8000_1000; m_ret = m_ret + 32'd1;
    n_cmp++; if (retire_cnt !== m_ret) begin
      n_bad++; $display("FAIL trap_retire: got %0d want %0d", retire_cnt, m_ret);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, g, d, iw, rt, tt, exp;
    logic        rv, tv, st, to;
    for (int i = 0; i < 16; i++) begin
      iw = $urandom;
      rv = 1'($urandom_range(0, 1));
      tv = ($urandom_range(0, 3) == 0);
      rt = $urandom & 32'hFFFF_FFFC;
      tt = $urandom & 32'hFFFF_FFFC;
      exp = tv ? tt : (rv ? rt : m_pc + 32'd4);
      drive_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'b0, rv, rt, tv, tt, 1'b0, iw, a, g, d, st, to);
      n_cmp++; if (to || a !== m_pc || g !== iw || !st) begin
        n_bad++; $display("FAIL rnd_fetch%0d: to=%b stable=%b addr=%h inst=%h want %h/%h", i, to, st, a, g, m_pc, iw);
      end
      m_ret = m_ret + 32'd1;
      n_cmp++; if (d !== exp || pc !== exp || retire_cnt !== m_ret) begin
        n_bad++; $display("FAIL rnd_commit%0d: dnpc=%h pc=%h retire=%0d want %h/%0d", i, d, pc, retire_cnt, exp, m_ret);
      end
      m_pc = exp;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, g, d;
    logic        st, to;
    drive_instr(5, 2, 4, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h0BAD_F00D, a, g, d, st, to);
    n_cmp++; if (to || !st) begin
      n_bad++; $display("FAIL bp_stable: timeout=%b stable=%b want 0/1", to, st);
    end
    n_cmp++; if (a !== m_pc || g !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL bp_data: addr=%h inst=%h want %h/0badf00d", a, g, m_pc);
    end
    m_pc = m_pc + 32'd4; m_ret = m_ret + 32'd1;
    n_cmp++; if (pc !== m_pc || retire_cnt !== m_ret) begin
      n_bad++; $display("FAIL bp_pc: pc=%h retire=%0d want %h/%0d", pc, retire_cnt, m_pc, m_ret);
    end
  endtask

  task automatic test_halt();
    logic [31:0] a, g, d;
    logic        st, to;
    drive_instr(0, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h1111_2222, a, g, d, st, to);
    m_pc = m_pc + 32'd4; m_ret = m_ret + 32'd1;
    n_cmp++; if (to || halted !== 1'b1 || pc !== m_pc || retire_cnt !== m_ret) begin
      n_bad++; $display("FAIL halt_commit: to=%b halted=%b pc=%h retire=%0d want 1/%h/%0d", to, halted, pc, retire_cnt, m_pc, m_ret);
    end
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; exec_ready = 1'b1; redirect_valid = 1'b1;
    tick(); tick();
    n_cmp++; if (halted !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fault !== 1'b0 || pc !== m_pc) begin
      n_bad++; $display("FAIL halt_hold: halted=%b req=%b iv=%b fault=%b pc=%h want 1/0/0/0/%h", halted, imem_req_valid, inst_valid, fault, pc, m_pc);
    end
    do_reset();
  endtask

  task automatic test_misalign();
    logic [31:0] a, g, d;
    logic        st, to;
    drive_instr(0, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h3333_0000, a, g, d, st, to);
    m_pc = m_pc + 32'd4; m_ret = m_ret + 32'd1;
    drive_instr(0, 0, 0, 1'b0, 1'b1, 32'h8000_0102, 1'b0, 32'd0, 1'b0, 32'h3333_0001, a, g, d, st, to);
    n_cmp++; if (to || fault !== 1'b1 || halted !== 1'b1) begin
      n_bad++; $display("FAIL mis_fault: to=%b fault=%b halted=%b want 1/1", to, fault, halted);
    end
    n_cmp++; if (pc !== m_pc || retire_cnt !== m_ret) begin
      n_bad++; $display("FAIL mis_state: pc=%h retire=%0d want %h/%0d", pc, retire_cnt, m_pc, m_ret);
    end
    tick();
    n_cmp++; if (fault !== 1'b0 || halted !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_bad++; $display("FAIL mis_after: fault=%b halted=%b req=%b iv=%b want 0/1/0/0", fault, halted, imem_req_valid, inst_valid);
    end
    do_reset();
  endtask

  task automatic test_fetch_err();
    logic [31:0] a, g, d;
    logic        st, to;
    drive_instr(1, 1, 1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h4444_0000, a, g, d, st, to);
    m_pc = m_pc + 32'd4; m_ret = m_ret + 32'd1;
    drive_instr(0, 2, 0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h4444_0001, a, g, d, st, to);
    n_cmp++; if (to || fault !== 1'b1 || halted !== 1'b1) begin
      n_bad++; $display("FAIL err_fault: to=%b fault=%b halted=%b want 1/1", to, fault, halted);
    end
    n_cmp++; if (pc !== m_pc || retire_cnt !== m_ret || inst_valid !== 1'b0) begin
      n_bad++; $display("FAIL err_state: pc=%h retire=%0d iv=%b want %h/%0d/0", pc, retire_cnt, inst_valid, m_pc, m_ret);
    end
    tick();
    n_cmp++; if (fault !== 1'b0 || halted !== 1'b1) begin
      n_bad++; $display("FAIL err_after: fault=%b halted=%b want 0/1", fault, halted);
    end
  endtask

  task automatic test_wrap_reset();
    clear_inputs();
    rst_w = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; exec_ready = 1'b1;
    imem_rsp_inst  = 32'hCAFE_0001;
    n_cmp++; if (w_req_valid !== 1'b1 || w_req_addr !== WRAP_PC) begin
      n_bad++; $display("FAIL wrap_req: valid=%b addr=%h want 1/%h", w_req_valid, w_req_addr, WRAP_PC);
    end
    tick(); tick();
    n_cmp++; if (w_inst_valid !== 1'b1 || w_inst !== 32'hCAFE_0001 || w_dnpc !== 32'd0) begin
      n_bad++; $display("FAIL wrap_issue: iv=%b inst=%h dnpc=%h want 1/cafe0001/0", w_inst_valid, w_inst, w_dnpc);
    end
    tick();
    n_cmp++; if (w_pc !== 32'd0 || w_retire !== 32'd1 || w_req_addr !== 32'd0) begin
      n_bad++; $display("FAIL wrap_pc: pc=%h retire=%0d addr=%h want 0/1/0", w_pc, w_retire, w_req_addr);
    end
    tick();
    clear_inputs();
    n_cmp++; if (w_req_valid !== 1'b0 || w_inst_valid !== 1'b0) begin
      n_bad++; $display("FAIL wrap_wait: req=%b iv=%b want 0/0", w_req_valid, w_inst_valid);
    end
    // Reset lands mid-cycle while the fetch of address 0 is outstanding.
    rst_w = 1'b1;
    #1;
    n_cmp++; if (w_pc !== WRAP_PC || w_retire !== 32'd0 || w_inst !== 32'd0 || w_req_valid !== 1'b1) begin
      n_bad++; $display("FAIL wrap_async_rst: pc=%h retire=%0d inst=%h req=%b want %h/0/0/1", w_pc, w_retire, w_inst, w_req_valid, WRAP_PC);
    end
    tick();
    rst_w = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_inst  = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (w_req_valid !== 1'b1 || w_req_addr !== WRAP_PC || w_inst_valid !== 1'b0 || w_inst !== 32'd0) begin
        n_bad++; $display("FAIL wrap_late_rsp%0d: req=%b addr=%h iv=%b inst=%h want 1/%h/0/0", i, w_req_valid, w_req_addr, w_inst_valid, w_inst, WRAP_PC);
      end
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    rst_w = 1'b1;
    m_pc  = RST_PC;
    m_ret = 32'd0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch_trap();
    test_back_to_back();
    test_backpressure();
    test_halt();
    test_misalign();
    test_fetch_err();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
